gray_counter: RTL
=================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and Gray output width (legal range 2..16).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port EN, input, 1 bit: count enable, one step per cycle while high.
REQ-005 SHALL have port UP_DN, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-006 SHALL have port LOAD, input, 1 bit: synchronous load strobe.
REQ-007 SHALL have port LOAD_VAL, input, WIDTH bits: binary value to load.
REQ-008 SHALL have port GRAY, output, WIDTH bits: registered Gray code, drives the downstream Gray-to-binary converter.
REQ-009 SHALL have port BIN, output, WIDTH bits: registered binary count, the golden reference for the downstream check.
REQ-010 SHALL have port TC, output, 1 bit: one-cycle terminal-count pulse.
REQ-011 SHALL have port CHG, output, 1 bit: one-cycle pulse when GRAY changed on this edge.

Function
REQ-012 SHALL apply priority per edge: RST, then LOAD, then EN, then hold.
REQ-013 SHALL, on LOAD, set BIN to LOAD_VAL and GRAY to LOAD_VAL ^ (LOAD_VAL >> 1) on the same edge, ignoring EN and UP_DN.
REQ-014 SHALL, on EN with LOAD low, set BIN to BIN+1 (UP_DN=1) or BIN-1 (UP_DN=0), modulo 2^WIDTH, with GRAY = f(next BIN) registered on the same edge.
REQ-015 SHALL have a latency of exactly one cycle from the sampled EN/LOAD to the updated GRAY and BIN; no combinational path from inputs to outputs.
REQ-016 SHALL guarantee that consecutive EN steps change exactly one GRAY bit, including across the wrap.
REQ-017 SHALL pulse TC high for one cycle after the edge on which an EN step crosses the boundary (up from 2^WIDTH-1, or down from 0); TC SHALL NOT be set by LOAD.
REQ-018 SHALL pulse CHG high for one cycle after any edge where GRAY's new value differs from its old value (EN step or LOAD of a different value); CHG SHALL be low for a LOAD of the current value.
REQ-019 SHALL treat UP_DN as a don't-care while EN and LOAD are both low; SHALL keep outputs stable while holding.

Reset
REQ-020 SHALL, with RST high at an edge, set GRAY=0, BIN=0, TC=0, CHG=0, overriding LOAD and EN, including mid-count.
REQ-021 SHALL resume counting from 0 on the first edge after RST falls with EN high.

Configuration
REQ-022 SHALL, with macro GRAY_COUNTER_SATURATE_EN defined, hold at 2^WIDTH-1 (up) or 0 (down) instead of wrapping, with TC pulsing on each blocked step and CHG low on those cycles.
REQ-023 SHALL, without GRAY_COUNTER_SATURATE_EN, wrap modulo 2^WIDTH per REQ-014 and REQ-017.

Structure
REQ-024 SHALL take the default width constant and a bin-to-gray helper function from the shared package gray_pkg, which is also used by the downstream converter's bench.
REQ-025 SHALL instantiate one combinational sub-module, bin2gray, mapping next BIN to next GRAY; the state register and control SHALL stay in gray_counter.

Verification
REQ-026 Bench SHALL run: RST then EN=1, UP_DN=1 for 16 cycles -> GRAY 0000,0001,0011,0010,0110,...,1000,0000; TC high once after the 1000->0000 step; CHG high every cycle.
REQ-027 Bench SHALL run: from reset, EN=1, UP_DN=0 for 1 cycle -> BIN=1111, GRAY=1000, TC=1.
REQ-028 Bench SHALL run: LOAD=1, LOAD_VAL=1010 with EN=1 -> BIN=1010, GRAY=1111, TC=0, CHG=1; repeat the same load -> CHG=0.
REQ-029 Bench SHALL run: reset asserted while BIN=0111 and EN=1 -> next cycle all outputs 0; after release one EN step -> GRAY=0001.
REQ-030 Bench SHALL run (SATURATE_EN build): LOAD 1111 then 3 up steps -> BIN stays 1111, GRAY=1000, TC=1 each cycle, CHG=0.
REQ-031 Bench SHALL check every cycle: GRAY fed to the Gray-to-binary converter equals BIN, and Hamming distance between successive GRAY values on EN steps equals 1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code package: default width, direction encoding and Gray/binary helpers.
// Also imported by the downstream Gray-to-binary converter's bench.
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_WIDTH_MAX     = 16;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Full-width helpers; callers zero-extend and truncate to their own width.
    function automatic logic [GRAY_WIDTH_MAX-1:0] bin_to_gray(input logic [GRAY_WIDTH_MAX-1:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    function automatic logic [GRAY_WIDTH_MAX-1:0] gray_to_bin(input logic [GRAY_WIDTH_MAX-1:0] gray);
        logic [GRAY_WIDTH_MAX-1:0] bin;
        bin[GRAY_WIDTH_MAX-1] = gray[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray mapper built on the shared package helper.
module bin2gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin_to_gray(GRAY_WIDTH_MAX'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with synchronous load, registered binary/Gray outputs,
// terminal-count and change pulses. Define GRAY_COUNTER_SATURATE_EN to saturate instead of wrap.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP_DN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] GRAY,
    output logic [WIDTH-1:0] BIN,
    output logic             TC,
    output logic             CHG
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             tc_r;
    logic             chg_r;

    logic [WIDTH-1:0] step_bin_s;
    logic [WIDTH-1:0] next_bin_s;
    logic [WIDTH-1:0] next_gray_s;
    logic             boundary_s;
    logic             next_tc_s;
    dir_e             dir_s;

    assign dir_s = dir_e'(UP_DN);

    // Next-state selection: LOAD beats EN; a step across the boundary raises TC.
    always_comb begin
        step_bin_s = bin_r;
        boundary_s = 1'b0;
        next_bin_s = bin_r;
        next_tc_s  = 1'b0;
        case (dir_s)
            DIR_UP: begin
                boundary_s = (bin_r == ALL_ONES);
                step_bin_s = bin_r + ONE;
            end
            DIR_DN: begin
                boundary_s = (bin_r == ALL_ZERO);
                step_bin_s = bin_r - ONE;
            end
            default: begin
                boundary_s = 1'b0;
                step_bin_s = bin_r;
            end
        endcase
        if (LOAD) begin
            next_bin_s = LOAD_VAL;
            next_tc_s  = 1'b0;
        end else if (EN) begin
            next_tc_s = boundary_s;
`ifdef GRAY_COUNTER_SATURATE_EN
            if (boundary_s) begin
                next_bin_s = bin_r;
            end else begin
                next_bin_s = step_bin_s;
            end
`else
            next_bin_s = step_bin_s;
`endif
        end else begin
            next_bin_s = bin_r;
            next_tc_s  = 1'b0;
        end
    end

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (next_bin_s),
        .gray (next_gray_s)
    );

    // State and pulse registers; CHG compares the new Gray word with the one it replaces.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_r  <= ALL_ZERO;
            gray_r <= ALL_ZERO;
            tc_r   <= 1'b0;
            chg_r  <= 1'b0;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= next_gray_s;
            tc_r   <= next_tc_s;
            chg_r  <= (next_gray_s != gray_r);
        end
    end

    assign GRAY = gray_r;
    assign BIN  = bin_r;
    assign TC   = tc_r;
    assign CHG  = chg_r;

endmodule
